vga_scan_fetch: RTL and testbench

Pixel-scan stage between the video memory and the VGA pins. Generates 640x480@60 Hz timing from the 50 MHz system clock using an internal divide-by-2 pixel enable. Drives the video memory read address for the 80x60 cell frame buffer (8x8-pixel cells) and captures the returned 3-bit colour. Emits RGB, HSYNC and VSYNC aligned to one another, plus a frame-start pulse and vertical-blank flag for the CPU.

---
 rtl/vga_scan_fetch_if.sv | 31 +++
 rtl/vga_scan_fetch.sv | 114 +++++++++++
 tb/tb_vga_scan_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_fetch_if.sv
// Bus between vga_scan_fetch and its video memory / VGA pins.
// master = scan-fetch side, slave = memory and display side.
interface vga_scan_fetch_if;
  logic [2:0]  iMemData;
  logic [12:0] oReadAddress;
  logic [2:0]  oVGA_RGB;
  logic        oHsync;
  logic        oVsync;
  logic        oFrameStart;
  logic        oVBlank;

  modport master (
    input  iMemData,
    output oReadAddress,
    output oVGA_RGB,
    output oHsync,
    output oVsync,
    output oFrameStart,
    output oVBlank
  );

  modport slave (
    output iMemData,
    input  oReadAddress,
    input  oVGA_RGB,
    input  oHsync,
    input  oVsync,
    input  oFrameStart,
    input  oVBlank
  );
endinterface

// File: rtl/vga_scan_fetch.sv
// 640x480@60 scan timing, 8x8-cell frame-buffer addressing and registered, mutually aligned pins.
// Define VGA_BORDER_EN to force BORDER_COLOR on the outermost ring of visible cells.
module vga_scan_fetch #(
  parameter int unsigned H_PW         = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned V_PW         = 2,
  parameter int unsigned V_BP         = 29,
  parameter int unsigned V_DISP       = 480,
  parameter int unsigned V_FP         = 10,
  parameter logic [2:0]  BORDER_COLOR = 3'b111
) (
  input logic              Clock,
  input logic              Reset,
  vga_scan_fetch_if.master bus
);

  localparam int unsigned H_TOTAL  = H_PW + H_BP + H_DISP + H_FP;
  localparam int unsigned V_TOTAL  = V_PW + V_BP + V_DISP + V_FP;
  localparam int unsigned H_VIS_LO = H_PW + H_BP;
  localparam int unsigned H_VIS_HI = H_VIS_LO + H_DISP;
  localparam int unsigned V_VIS_LO = V_PW + V_BP;
  localparam int unsigned V_VIS_HI = V_VIS_LO + V_DISP;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);

`ifdef VGA_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  logic           r_pixel_en;
  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;
  logic [2:0]     r_rgb;
  logic           r_hsync;
  logic           r_vsync;
  logic           r_frame_start;
  logic           r_vblank;

  logic [H_W-1:0] w_h_next;
  logic [V_W-1:0] w_v_next;
  logic           w_vis_col;
  logic           w_vis_line;
  logic           w_visible;
  logic [6:0]     w_col;
  logic [5:0]     w_row;
  logic           w_border;
  logic [2:0]     w_pix;

  always_comb begin
    w_vis_col  = (r_h >= H_W'(H_VIS_LO)) && (r_h < H_W'(H_VIS_HI));
    w_vis_line = (r_v >= V_W'(V_VIS_LO)) && (r_v < V_W'(V_VIS_HI));
    w_visible  = w_vis_col && w_vis_line;
    w_col      = 7'((r_h - H_W'(H_VIS_LO)) >> 3);
    w_row      = 6'((r_v - V_W'(V_VIS_LO)) >> 3);
    w_border   = (w_col == 7'd0) || (w_col == 7'(H_DISP / 8 - 1)) ||
                 (w_row == 6'd0) || (w_row == 6'(V_DISP / 8 - 1));
  end

  always_comb begin
    w_h_next = r_h + H_W'(1);
    w_v_next = r_v;
    if (r_h == H_W'(H_TOTAL - 1)) begin
      w_h_next = '0;
      w_v_next = (r_v == V_W'(V_TOTAL - 1)) ? '0 : r_v + V_W'(1);
    end
  end

  // Memory data arriving now belongs to the current (pre-advance) counters.
  always_comb begin
    w_pix = 3'b000;
    if (w_visible) begin
      w_pix = (BORDER_EN && w_border) ? BORDER_COLOR : bus.iMemData;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pixel_en    <= 1'b0;
      r_h           <= '0;
      r_v           <= '0;
      r_rgb         <= 3'b000;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
      r_vblank      <= 1'b1;
    end else begin
      r_pixel_en    <= ~r_pixel_en;
      r_frame_start <= 1'b0;
      if (r_pixel_en) begin
        r_h           <= w_h_next;
        r_v           <= w_v_next;
        r_rgb         <= w_pix;
        r_hsync       <= ~(r_h < H_W'(H_PW));
        r_vsync       <= ~(r_v < V_W'(V_PW));
        r_vblank      <= ~w_vis_line;
        r_frame_start <= (r_h == '0) && (r_v == '0);
      end
    end
  end

  always_comb begin
    bus.oReadAddress = w_visible ? {w_col, w_row} : 13'd0;
    bus.oVGA_RGB     = r_rgb;
    bus.oHsync       = r_hsync;
    bus.oVsync       = r_vsync;
    bus.oFrameStart  = r_frame_start;
    bus.oVBlank      = r_vblank;
  end

endmodule

// File: tb/tb_vga_scan_fetch.sv
// Bench for vga_scan_fetch: a full-size instance (reset, hsync, addressing, first visible lines)
// and a shrunken-geometry instance (whole frames, vsync timing, mid-frame reset).
`timescale 1ns/1ps
module tb_vga_scan_fetch;

  localparam logic [6:0] RST_PIX = 7'b000_1_1_0_1;  // {rgb, hs, vs, fs, vb}
  localparam int LIMIT_A = 70000;

  typedef struct { logic [6:0] pix; int v; } sb_t;
  typedef struct { int h; int v; logic [12:0] addr; } vec_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  bit   b_active = 1'b0;
  bit   b_done = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_scan_fetch_if bus_a ();
  vga_scan_fetch_if bus_b ();

  vga_scan_fetch u_dut_a (
    .Clock (clk),
    .Reset (rst_a_n),
    .bus   (bus_a)
  );

  vga_scan_fetch #(
    .H_PW(4), .H_BP(4), .H_DISP(32), .H_FP(4),
    .V_PW(2), .V_BP(3), .V_DISP(32), .V_FP(2)
  ) u_dut_b (
    .Clock (clk),
    .Reset (rst_b_n),
    .bus   (bus_b)
  );

  logic [6:0] act_a, act_b;
  assign act_a = {bus_a.oVGA_RGB, bus_a.oHsync, bus_a.oVsync, bus_a.oFrameStart, bus_a.oVBlank};
  assign act_b = {bus_b.oVGA_RGB, bus_b.oHsync, bus_b.oVsync, bus_b.oFrameStart, bus_b.oVBlank};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    tot_cnt++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Memory contents: A shows column[2:0], B mixes row in so row addressing is exercised too.
  function automatic logic [2:0] mem_val(input bit sel_b, input int col, input int row);
`ifdef VGA_BORDER_EN
    return 3'b010;
`else
    logic [6:0] c;
    logic [5:0] r;
    c = 7'(col);
    r = 6'(row);
    return sel_b ? (c[2:0] ^ r[2:0]) : c[2:0];
`endif
  endfunction

  function automatic logic [6:0] exp_pix(input int h, input int v, input int hpw, input int hbp,
                                         input int hdisp, input int vpw, input int vbp,
                                         input int vdisp, input bit sel_b);
    bit vl, vc;
    int col, row;
    logic [2:0] rgb;
    vl  = (v >= vpw + vbp) && (v < vpw + vbp + vdisp);
    vc  = (h >= hpw + hbp) && (h < hpw + hbp + hdisp);
    col = (h - hpw - hbp) / 8;
    row = (v - vpw - vbp) / 8;
    rgb = 3'b000;
    if (vl && vc) begin
      rgb = mem_val(sel_b, col, row);
`ifdef VGA_BORDER_EN
      if (col == 0 || col == hdisp / 8 - 1 || row == 0 || row == vdisp / 8 - 1) rgb = 3'b111;
`endif
    end
    return {rgb, 1'(h >= hpw), 1'(v >= vpw), 1'(h == 0 && v == 0), 1'(!vl)};
  endfunction

  function automatic logic [12:0] exp_addr(input int h, input int v, input int hpw, input int hbp,
                                           input int hdisp, input int vpw, input int vbp,
                                           input int vdisp);
    if ((h >= hpw + hbp) && (h < hpw + hbp + hdisp) && (v >= vpw + vbp) && (v < vpw + vbp + vdisp))
      return {7'((h - hpw - hbp) / 8), 6'((v - vpw - vbp) / 8)};
    return 13'd0;
  endfunction

  function automatic sb_t mk(input logic [6:0] pix, input int v);
    return '{pix: pix, v: v};
  endfunction

  function automatic sb_t clr_fs(input sb_t s);
    return '{pix: s.pix & 7'b1111101, v: s.v};
  endfunction

  function automatic bit win_a(input int v);
    return (v <= 1) || (v >= 30 && v <= 32) || (v == 39);
  endfunction

  // Video memory models: registered read, one Clock latency.
  always @(posedge clk) begin
    bus_a.iMemData <= mem_val(1'b0, int'(bus_a.oReadAddress[12:6]), int'(bus_a.oReadAddress[5:0]));
    bus_b.iMemData <= mem_val(1'b1, int'(bus_b.oReadAddress[12:6]), int'(bus_b.oReadAddress[5:0]));
  end

  // Reference scan position and expected-pin scoreboards, one entry per Clock.
  bit  ma_pe, mb_pe;
  int  ma_h, ma_v, mb_h, mb_v;
  sb_t ma_last, mb_last;
  sb_t q_a[$];
  sb_t q_b[$];

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      ma_pe   <= 1'b0;
      ma_h    <= 0;
      ma_v    <= 0;
      ma_last <= mk(RST_PIX, -1);
      q_a.delete();
    end else begin
      ma_pe <= !ma_pe;
      if (ma_pe) begin
        q_a.push_back(mk(exp_pix(ma_h, ma_v, 96, 48, 640, 2, 29, 480, 1'b0), ma_v));
        ma_last <= mk(exp_pix(ma_h, ma_v, 96, 48, 640, 2, 29, 480, 1'b0), ma_v);
        if (ma_h == 799) begin
          ma_h <= 0;
          ma_v <= (ma_v == 520) ? 0 : ma_v + 1;
        end else ma_h <= ma_h + 1;
      end else q_a.push_back(clr_fs(ma_last));
    end
  end

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      mb_pe   <= 1'b0;
      mb_h    <= 0;
      mb_v    <= 0;
      mb_last <= mk(RST_PIX, -1);
      q_b.delete();
    end else begin
      mb_pe <= !mb_pe;
      if (mb_pe) begin
        q_b.push_back(mk(exp_pix(mb_h, mb_v, 4, 4, 32, 2, 3, 32, 1'b1), mb_v));
        mb_last <= mk(exp_pix(mb_h, mb_v, 4, 4, 32, 2, 3, 32, 1'b1), mb_v);
        if (mb_h == 43) begin
          mb_h <= 0;
          mb_v <= (mb_v == 38) ? 0 : mb_v + 1;
        end else mb_h <= mb_h + 1;
      end else q_b.push_back(clr_fs(mb_last));
    end
  end

  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      if (win_a(q_a[0].v)) check("pins_a", 32'(act_a), 32'(q_a[0].pix));
      void'(q_a.pop_front());
    end
    if (q_b.size() > 0) begin
      check("pins_b", 32'(act_b), 32'(q_b[0].pix));
      void'(q_b.pop_front());
    end
    if (b_active && rst_b_n)
      check("addr_b", 32'(bus_b.oReadAddress), 32'(exp_addr(mb_h, mb_v, 4, 4, 32, 2, 3, 32)));
  end

  // Sync edge timestamps for period / width measurement.
  logic hs_a_prev = 1'b1;
  logic vs_b_prev = 1'b1;
  int   hs_fall_a[$], hs_rise_a[$], vs_fall_b[$], vs_rise_b[$];

  always @(negedge clk) begin
    if (rst_a_n) begin
      if (hs_a_prev && !bus_a.oHsync) hs_fall_a.push_back(cyc);
      if (!hs_a_prev && bus_a.oHsync) hs_rise_a.push_back(cyc);
    end
    if (b_active && rst_b_n) begin
      if (vs_b_prev && !bus_b.oVsync) vs_fall_b.push_back(cyc);
      if (!vs_b_prev && bus_b.oVsync) vs_rise_b.push_back(cyc);
    end
    hs_a_prev <= bus_a.oHsync;
    vs_b_prev <= bus_b.oVsync;
  end

  // Full-size instance.
  initial begin
    vec_t tbl[11];
    bit   found;
    tbl[0]  = '{100, 0,  13'd0};
    tbl[1]  = '{144, 0,  13'd0};
    tbl[2]  = '{500, 30, 13'd0};
    tbl[3]  = '{144, 31, 13'd0};
    tbl[4]  = '{152, 31, {7'd1, 6'd0}};
    tbl[5]  = '{783, 31, {7'd79, 6'd0}};
    tbl[6]  = '{790, 31, 13'd0};
    tbl[7]  = '{143, 32, 13'd0};
    tbl[8]  = '{300, 35, {7'd19, 6'd0}};
    tbl[9]  = '{160, 39, {7'd2, 6'd1}};
    tbl[10] = '{783, 39, {7'd79, 6'd1}};

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_hold_a", 32'(act_a), 32'(RST_PIX));
    end
    rst_a_n = 1'b1;
    @(posedge clk); #1 check("frame_start_clk1", 32'(bus_a.oFrameStart), 32'd0);
    @(posedge clk); #1 check("frame_start_clk2", 32'(bus_a.oFrameStart), 32'd1);
    @(posedge clk); #1 check("frame_start_clk3", 32'(bus_a.oFrameStart), 32'd0);

    for (int i = 0; i < 11; i++) begin
      found = 1'b0;
      while (!found && cyc < LIMIT_A) begin
        @(negedge clk);
        found = (ma_h == tbl[i].h) && (ma_v == tbl[i].v);
      end
      if (found) check($sformatf("addr_a[%0d]", i), 32'(bus_a.oReadAddress), 32'(tbl[i].addr));
      else fail($sformatf("addr_a[%0d]", i));
    end

    if (hs_fall_a.size() >= 4 && hs_rise_a.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("hsync_period", 32'(hs_fall_a[i+1] - hs_fall_a[i]), 32'd1600);
        check("hsync_low", 32'(hs_rise_a[i] - hs_fall_a[i]), 32'd192);
      end
    end else fail("hsync_edges");

    while (!b_done && cyc < LIMIT_A + 20000) @(negedge clk);
    if (!b_done) fail("bench_b_done");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  // Shrunken instance: 44x39 geometry, 3432-Clock frame.
  initial begin
    bit found;
    repeat (5) @(negedge clk);
    rst_b_n  = 1'b1;
    b_active = 1'b1;

    while (vs_fall_b.size() < 3 && cyc < 12000) @(negedge clk);
    if (vs_fall_b.size() >= 3 && vs_rise_b.size() >= 1) begin
      check("vsync_period0", 32'(vs_fall_b[1] - vs_fall_b[0]), 32'd3432);
      check("vsync_period1", 32'(vs_fall_b[2] - vs_fall_b[1]), 32'd3432);
      check("vsync_low", 32'(vs_rise_b[0] - vs_fall_b[0]), 32'd176);
    end else fail("vsync_edges");

    found = 1'b0;
    while (!found && cyc < 20000) begin
      @(negedge clk);
      found = (mb_v == 20) && (mb_h == 10);
    end
    if (!found) fail("reach_v20_b");
    #3 rst_b_n = 1'b0;
    #1 check("midframe_reset_pins", 32'(act_b), 32'(RST_PIX));
    check("midframe_reset_addr", 32'(bus_b.oReadAddress), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b_n = 1'b1;
    @(posedge clk); #1 check("restart_vsync_clk1", 32'(bus_b.oVsync), 32'd1);
    @(posedge clk); #1 check("restart_vsync_clk2", 32'(bus_b.oVsync), 32'd0);
    check("restart_frame_start", 32'(bus_b.oFrameStart), 32'd1);
    repeat (400) @(negedge clk);
    b_done = 1'b1;
  end

endmodule
